sm83_irq_sched: RTL and testbench
=================================

// Module: sm83_irq_sched
// PURPOSE
//  Interrupt scheduler for the sm83 core: owns IME, the EI delay, HALT state and the
//  5-M-cycle interrupt dispatch sequence. Sits beside sm83_control; consumes masked IRQ
//  lines (IF & IE) and timing strobes, drives iack and vector to the core, and tells
//  sm83_control when to substitute a dispatch for the next opcode fetch.
// PARAMETERS
//  NUM_IRQS   8      number of interrupt lines; bit 0 = highest priority
//  WORD_SIZE  8      data word width (vector output width)
//  VEC_BASE   8'h40  low byte of the vector for irq[0]
//  VEC_SHIFT  3      vector stride = 1<<VEC_SHIFT bytes per line
// PORTS
//  clk          in   1          core clock; all state changes on posedge
//  reset        in   1          synchronous, active-high
//  t4           in   1          strobe: last clock of every M-cycle
//  insn_end     in   1          high with t4 of an instruction's last M-cycle
//  ctl_ei       in   1          EI executing (sampled with insn_end)
//  ctl_di       in   1          DI executing (sampled with insn_end)
//  ctl_reti     in   1          RETI executing (sampled with insn_end)
//  ctl_halt     in   1          HALT executing (sampled with insn_end)
//  irq          in   NUM_IRQS   pending & enabled requests, level
//  ime          out  1          interrupt master enable
//  halted       out  1          core stopped; fetch suppressed
//  halt_bug     out  1          one-clock pulse: next fetch must not increment PC
//  dispatch     out  1          dispatch sequence active (replaces fetch)
//  dsp_m        out  5          one-hot dispatch M-cycle (M1..M5)
//  iack         out  NUM_IRQS   one-hot acknowledge pulse, clears IF bit
//  vec          out  WORD_SIZE  low byte of target PC; high byte is 0
// BEHAVIOUR
//  Reset: ime=0, ei_pend=0, halted=0, halt_bug=0, dispatch=0, dsp_m=0, iack=0, vec=0; IDLE.
//  Boundary = clock where t4 && insn_end (IDLE) or t4 (HALTED). Nothing changes off-strobe.
//  IME: at boundary, DI clears ime and ei_pend (DI wins over every other source);
//   RETI sets ime; EI sets ei_pend only; ei_pend promotes to ime at the NEXT boundary.
//   An interrupt is never taken at the boundary closing EI itself (uses pre-update ime).
//  IDLE: at boundary, if ime && |irq -> DSP_M1, ime<=0, ei_pend<=0; else if ctl_halt:
//   if !ime && |irq -> stay IDLE, halt_bug pulses 1 clock; else -> HALTED.
//  HALTED: halted=1. At each t4: if |irq then (ime ? DSP_M1 with ime<=0 : IDLE); halted
//   drops on that same clock. Otherwise remain.
//  DSP_M1..M5: advance one state per t4; dispatch=1, dsp_m one-hot mirrors state.
//   M1 PC adjust, M2 SP dec, M3 push PCH, M4 push PCL, M5 load PC<=vec.
//  Priority latched at t4 closing M3 (after PCH push): idx = lowest set bit of irq;
//   iack[idx] pulses for exactly that clock; vec = VEC_BASE + (idx<<VEC_SHIFT).
//   If irq==0 at that point: iack=0, vec=8'h00 (dispatch to 0x0000), sequence completes.
//  vec holds until next latch. M5 t4 -> IDLE; ei/di/reti/halt ignored while dispatching.
//  Reset mid-dispatch or mid-halt: return to reset values next clock, no iack emitted.
// STRUCTURE
//  sm83_pkg: irq_t, enum sched_state_t {IDLE, HALTED, DSP_M1..DSP_M5}, VEC_* constants.
//  Sub-module sm83_irq_prio: combinational lowest-bit priority encoder -> onehot, index, any.
//  State register + IME/ei_pend flops in this module; outputs registered except dsp_m decode.
// TESTING
//  EI;NOP with irq=8'h04 -> no dispatch after EI, dispatch after NOP; iack=8'h04, vec=8'h50.
//  ime=1, irq=8'h1F at boundary -> dsp_m 1,2,4,8,16 on successive t4s; iack=8'h01, vec=8'h40.
//  Dispatch with irq dropped to 0 before M3 t4 -> iack never asserts, vec=8'h00, ime=0 after.
//  HALT with ime=0, irq=0; raise irq=8'h10 -> halted falls at next t4, no dispatch, ime=0.
//  HALT with ime=0, irq=8'h02 already set -> halted stays 0, halt_bug one-clock pulse.
//  EI and DI on consecutive boundaries, then reset during DSP_M2 -> ime=0, IDLE, iack=0.

Source files
------------

// File: rtl/sm83_pkg.sv
// Shared types and defaults for the sm83 interrupt scheduler.
package sm83_pkg;

    localparam int unsigned SM83_NUM_IRQS  = 8;
    localparam int unsigned SM83_WORD_SIZE = 8;
    localparam int unsigned SM83_VEC_SHIFT = 3;
    localparam logic [7:0]  SM83_VEC_BASE  = 8'h40;

    typedef logic [SM83_NUM_IRQS-1:0] irq_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HALTED = 3'd1,
        DSP_M1 = 3'd2,
        DSP_M2 = 3'd3,
        DSP_M3 = 3'd4,
        DSP_M4 = 3'd5,
        DSP_M5 = 3'd6
    } sched_state_t;

    function automatic logic is_dispatch(input sched_state_t s);
        return s inside {DSP_M1, DSP_M2, DSP_M3, DSP_M4, DSP_M5};
    endfunction

    // One-hot M-cycle marker for the dispatch states, zero elsewhere.
    function automatic logic [4:0] dsp_onehot(input sched_state_t s);
        logic [4:0] m;
        case (s)
            DSP_M1:  m = 5'b00001;
            DSP_M2:  m = 5'b00010;
            DSP_M3:  m = 5'b00100;
            DSP_M4:  m = 5'b01000;
            DSP_M5:  m = 5'b10000;
            default: m = 5'b00000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sm83_irq_prio.sv
// Lowest-index-wins priority encoder: one-hot grant, binary index and any-request flag.
module sm83_irq_prio #(
    parameter int unsigned N = 8,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = |req;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot = N'(1) << i;
                idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sm83_irq_sched.sv
// Interrupt scheduler: IME / EI delay, HALT handling and the 5-M-cycle dispatch sequence.
module sm83_irq_sched
    import sm83_pkg::*;
#(
    parameter int unsigned            NUM_IRQS  = SM83_NUM_IRQS,
    parameter int unsigned            WORD_SIZE = SM83_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0]   VEC_BASE  = WORD_SIZE'(SM83_VEC_BASE),
    parameter int unsigned            VEC_SHIFT = SM83_VEC_SHIFT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  t4,
    input  logic                  insn_end,
    input  logic                  ctl_ei,
    input  logic                  ctl_di,
    input  logic                  ctl_reti,
    input  logic                  ctl_halt,
    input  logic [NUM_IRQS-1:0]   irq,
    output logic                  ime,
    output logic                  halted,
    output logic                  halt_bug,
    output logic                  dispatch,
    output logic [4:0]            dsp_m,
    output logic [NUM_IRQS-1:0]   iack,
    output logic [WORD_SIZE-1:0]  vec
);

    localparam int unsigned IDX_W = (NUM_IRQS > 1) ? $clog2(NUM_IRQS) : 1;

    sched_state_t         state_q, state_d;
    logic                 ime_q, ime_d;
    logic                 ei_pend_q, ei_pend_d;
    logic                 halted_q, halted_d;
    logic                 halt_bug_q, halt_bug_d;
    logic                 dispatch_q, dispatch_d;
    logic [NUM_IRQS-1:0]  iack_q, iack_d;
    logic [WORD_SIZE-1:0] vec_q, vec_d;

    logic [NUM_IRQS-1:0]  irq_onehot;
    logic [IDX_W-1:0]     irq_idx;
    logic                 irq_any;
    logic                 boundary_c;
    logic                 ime_eff_c;
    logic                 take_c;

    sm83_irq_prio #(.N(NUM_IRQS)) u_prio (
        .req    (irq),
        .onehot (irq_onehot),
        .idx    (irq_idx),
        .any    (irq_any)
    );

    // A pending EI counts as enabled at the boundary after it, never at its own.
    assign boundary_c = t4 & insn_end;
    assign ime_eff_c  = ime_q | ei_pend_q;
    assign take_c     = boundary_c & ime_eff_c & irq_any;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ime_q      <= 1'b0;
            ei_pend_q  <= 1'b0;
            halted_q   <= 1'b0;
            halt_bug_q <= 1'b0;
            dispatch_q <= 1'b0;
            iack_q     <= '0;
            vec_q      <= '0;
        end else begin
            state_q    <= state_d;
            ime_q      <= ime_d;
            ei_pend_q  <= ei_pend_d;
            halted_q   <= halted_d;
            halt_bug_q <= halt_bug_d;
            dispatch_q <= dispatch_d;
            iack_q     <= iack_d;
            vec_q      <= vec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take_c)
                    state_d = DSP_M1;
                else if (boundary_c && ctl_halt && !irq_any)
                    state_d = HALTED;
            end
            HALTED: begin
                if (t4 && irq_any)
                    state_d = ime_q ? DSP_M1 : IDLE;
            end
            DSP_M1:  if (t4) state_d = DSP_M2;
            DSP_M2:  if (t4) state_d = DSP_M3;
            DSP_M3:  if (t4) state_d = DSP_M4;
            DSP_M4:  if (t4) state_d = DSP_M5;
            DSP_M5:  if (t4) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ime_d      = ime_q;
        ei_pend_d  = ei_pend_q;
        halt_bug_d = 1'b0;
        iack_d     = '0;
        vec_d      = vec_q;
        halted_d   = (state_d == HALTED);
        dispatch_d = is_dispatch(state_d);
        dsp_m      = dsp_onehot(state_q);
        case (state_q)
            IDLE: begin
                if (boundary_c) begin
                    if (take_c || ctl_di) begin
                        ime_d     = 1'b0;
                        ei_pend_d = 1'b0;
                    end else begin
                        ime_d      = ime_eff_c | ctl_reti;
                        ei_pend_d  = ctl_ei;
                        halt_bug_d = ctl_halt & irq_any;
                    end
                end
            end
            HALTED: begin
                if (t4 && irq_any && ime_q) begin
                    ime_d     = 1'b0;
                    ei_pend_d = 1'b0;
                end
            end
            // Priority is resolved only after PCH is on the stack.
            DSP_M3: begin
                if (t4) begin
                    iack_d = irq_onehot;
                    vec_d  = irq_any ? (VEC_BASE + (WORD_SIZE'(irq_idx) << VEC_SHIFT))
                                     : '0;
                end
            end
            default: ;
        endcase
    end

    assign ime      = ime_q;
    assign halted   = halted_q;
    assign halt_bug = halt_bug_q;
    assign dispatch = dispatch_q;
    assign iack     = iack_q;
    assign vec      = vec_q;

endmodule

// File: tb/tb_sm83_irq_sched.sv
// Directed bench for sm83_irq_sched with a cycle-level reference model and per-cycle compare.
module tb_sm83_irq_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       t4 = 1'b0;
    logic       insn_end = 1'b0;
    logic       ctl_ei = 1'b0;
    logic       ctl_di = 1'b0;
    logic       ctl_reti = 1'b0;
    logic       ctl_halt = 1'b0;
    logic [7:0] irq = 8'h00;
    logic       ime, halted, halt_bug, dispatch;
    logic [4:0] dsp_m;
    logic [7:0] iack, vec;

    int n_chk = 0;
    int n_fail = 0;
    int iack_cnt = 0;
    int snap;

    // Reference model: mode 0 = running, 1 = halted, 2 = dispatching (step 1..5).
    int         m_mode = 0;
    int         m_step = 0;
    logic       m_ime = 1'b0;
    logic       m_pend = 1'b0;
    logic       m_hbug = 1'b0;
    logic [7:0] m_iack = 8'h00;
    logic [7:0] m_vec = 8'h00;

    sm83_irq_sched dut (
        .clk      (clk),
        .reset    (reset),
        .t4       (t4),
        .insn_end (insn_end),
        .ctl_ei   (ctl_ei),
        .ctl_di   (ctl_di),
        .ctl_reti (ctl_reti),
        .ctl_halt (ctl_halt),
        .irq      (irq),
        .ime      (ime),
        .halted   (halted),
        .halt_bug (halt_bug),
        .dispatch (dispatch),
        .dsp_m    (dsp_m),
        .iack     (iack),
        .vec      (vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest_bit(input logic [7:0] v);
        for (int i = 0; i < 8; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_step = 0; m_ime = 0; m_pend = 0;
            m_hbug = 0; m_iack = 8'h00; m_vec = 8'h00;
        end else begin
            m_hbug = 0;
            m_iack = 8'h00;
            if (t4) begin
                if (m_mode == 0 && insn_end) begin
                    if ((m_ime || m_pend) && irq != 0) begin
                        m_mode = 2; m_step = 1; m_ime = 0; m_pend = 0;
                    end else if (ctl_di) begin
                        m_ime = 0; m_pend = 0;
                    end else begin
                        m_ime  = m_ime | m_pend | ctl_reti;
                        m_pend = ctl_ei;
                        if (ctl_halt) begin
                            if (irq != 0) m_hbug = 1;
                            else          m_mode = 1;
                        end
                    end
                end else if (m_mode == 1) begin
                    if (irq != 0) begin
                        if (m_ime) begin
                            m_mode = 2; m_step = 1; m_ime = 0; m_pend = 0;
                        end else begin
                            m_mode = 0;
                        end
                    end
                end else if (m_mode == 2) begin
                    if (m_step == 3) begin
                        if (irq != 0) begin
                            m_iack = 8'h01 << lowest_bit(irq);
                            m_vec  = 8'h40 + 8'(8 * lowest_bit(irq));
                        end else begin
                            m_vec = 8'h00;
                        end
                    end
                    if (m_step == 5) begin
                        m_mode = 0; m_step = 0;
                    end else begin
                        m_step++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("ime", 32'(ime), 32'(m_ime));
        check("halted", 32'(halted), 32'(m_mode == 1));
        check("halt_bug", 32'(halt_bug), 32'(m_hbug));
        check("dispatch", 32'(dispatch), 32'(m_mode == 2));
        check("dsp_m", 32'(dsp_m), (m_mode == 2) ? (32'd1 << (m_step - 1)) : 32'd0);
        check("iack", 32'(iack), 32'(m_iack));
        check("vec", 32'(vec), 32'(m_vec));
        if (iack != 8'h00) iack_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One M-cycle of four clocks; strobes and controls are presented on the last clock.
    task automatic mcyc(input logic ie, input logic e, input logic d,
                        input logic r, input logic h);
        repeat (3) tick();
        t4 = 1'b1; insn_end = ie; ctl_ei = e; ctl_di = d; ctl_reti = r; ctl_halt = h;
        tick();
        t4 = 1'b0; insn_end = 1'b0; ctl_ei = 1'b0; ctl_di = 1'b0; ctl_reti = 1'b0; ctl_halt = 1'b0;
    endtask

    task automatic nop();
        mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ei();
        mcyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic di();
        mcyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic mid();
        mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        check("rst_ime", 32'(ime), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_dispatch", 32'(dispatch), 32'd0);
        check("rst_dsp_m", 32'(dsp_m), 32'd0);
        check("rst_iack", 32'(iack), 32'd0);
        check("rst_vec", 32'(vec), 32'd0);

        // EI;NOP with a pending line: no dispatch at EI, dispatch at NOP.
        irq = 8'h04;
        snap = iack_cnt;
        ei();
        check("ei_no_dispatch", 32'(dispatch), 32'd0);
        check("ei_ime_delayed", 32'(ime), 32'd0);
        nop();
        check("nop_dispatch", 32'(dispatch), 32'd1);
        repeat (3) mid();
        check("ei_iack", 32'(iack), 32'h04);
        check("ei_vec", 32'(vec), 32'h50);
        repeat (2) mid();
        check("ei_done", 32'(dispatch), 32'd0);
        check("ei_iack_once", 32'(iack_cnt - snap), 32'd1);
        irq = 8'h00;

        // Full dispatch walk with several lines pending; line 0 wins.
        ei(); nop();
        check("ime_set", 32'(ime), 32'd1);
        irq = 8'h1F;
        nop();
        check("walk_m1", 32'(dsp_m), 32'd1);
        check("walk_ime_clr", 32'(ime), 32'd0);
        for (int k = 1; k < 5; k++) begin
            mid();
            check("walk_dsp_m", 32'(dsp_m), 32'd1 << k);
            if (k == 3) begin
                check("walk_iack", 32'(iack), 32'h01);
                check("walk_vec", 32'(vec), 32'h40);
            end
        end
        mid();
        check("walk_done", 32'(dispatch), 32'd0);
        irq = 8'h00;

        // Request withdrawn before priority latch: dispatch to 0x0000, no ack.
        ei(); nop();
        irq = 8'h08;
        snap = iack_cnt;
        nop();
        mid();
        irq = 8'h00;
        repeat (2) mid();
        check("drop_iack", 32'(iack), 32'h00);
        check("drop_vec", 32'(vec), 32'h00);
        repeat (2) mid();
        check("drop_no_ack", 32'(iack_cnt - snap), 32'd0);
        check("drop_ime", 32'(ime), 32'd0);

        // HALT with IME off and nothing pending, then wake without dispatch.
        mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("halt_enter", 32'(halted), 32'd1);
        repeat (2) mid();
        check("halt_stay", 32'(halted), 32'd1);
        irq = 8'h10;
        mid();
        check("halt_wake", 32'(halted), 32'd0);
        check("halt_wake_nodsp", 32'(dispatch), 32'd0);
        check("halt_wake_ime", 32'(ime), 32'd0);
        irq = 8'h00;

        // HALT with IME off and a line already pending: halt bug.
        irq = 8'h02;
        mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("hbug_not_halted", 32'(halted), 32'd0);
        check("hbug_pulse", 32'(halt_bug), 32'd1);
        tick();
        check("hbug_one_clock", 32'(halt_bug), 32'd0);
        irq = 8'h00;

        // EI;HALT enters halt with IME on, wake dispatches.
        ei();
        mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("eihalt_halted", 32'(halted), 32'd1);
        check("eihalt_ime", 32'(ime), 32'd1);
        irq = 8'h04;
        snap = iack_cnt;
        mid();
        check("eihalt_dispatch", 32'(dispatch), 32'd1);
        check("eihalt_ime_clr", 32'(ime), 32'd0);
        repeat (5) mid();
        check("eihalt_ack", 32'(iack_cnt - snap), 32'd1);
        check("eihalt_vec", 32'(vec), 32'h50);
        irq = 8'h00;

        // RETI enables IME immediately; DI clears it.
        mcyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("reti_ime", 32'(ime), 32'd1);
        di();
        check("di_ime", 32'(ime), 32'd0);

        // EI then DI: DI cancels the pending enable.
        ei(); di(); nop();
        check("eidi_ime", 32'(ime), 32'd0);

        // Reset during DSP_M2.
        ei(); nop();
        irq = 8'h01;
        nop();
        mid();
        check("pre_rst_m2", 32'(dsp_m), 32'd2);
        snap = iack_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_m2_ime", 32'(ime), 32'd0);
        check("rst_m2_dispatch", 32'(dispatch), 32'd0);
        check("rst_m2_iack", 32'(iack), 32'd0);
        check("rst_m2_vec", 32'(vec), 32'd0);
        repeat (4) mid();
        check("rst_m2_no_ack", 32'(iack_cnt - snap), 32'd0);
        irq = 8'h00;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
